// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: data-type codes, header field positions and the
// depacketizer state encoding.
package csi2_pkg;

  localparam logic [5:0] DT_FS   = 6'h00;
  localparam logic [5:0] DT_FE   = 6'h01;
  localparam logic [5:0] DT_RAW8 = 6'h2A;

  // Packet header layout: DI = {VC, DT}, WC little-endian, ECC on top.
  localparam int DI_LSB  = 0;
  localparam int DT_MSB  = 5;
  localparam int VC_LSB  = 6;
  localparam int DI_MSB  = 7;
  localparam int WC_LSB  = 8;
  localparam int WC_MSB  = 23;
  localparam int ECC_LSB = 24;
  localparam int ECC_MSB = 31;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  // Byte enables for a payload word given the bytes still owed on the line.
  function automatic logic [3:0] be_for_rem(input logic [15:0] rem);
    logic [3:0] be;
    if (rem >= 16'd4) begin
      be = 4'hF;
    end else begin
      case (rem[1:0])
        2'd1:    be = 4'h1;
        2'd2:    be = 4'h3;
        2'd3:    be = 4'h7;
        default: be = 4'h0;
      endcase
    end
    return be;
  endfunction

endpackage

// File: rtl/csi2_hdr_decode.sv
// Combinational CSI-2 packet header classifier, shared by the depacketizers.
// Only the first matching flag matters to consumers; ECC failure masks all others.
module csi2_hdr_decode #(
  parameter logic [5:0] DT_RAW8 = csi2_pkg::DT_RAW8,
  parameter int         MAX_WC  = 4096
) (
  input  logic [31:0] hdr,
  input  logic        hdr_ok,
  output logic        is_fs,
  output logic        is_fe,
  output logic        is_raw8_ok,
  output logic        len_err,
  output logic        ecc_err,
  output logic [15:0] wc
);
  import csi2_pkg::*;

  logic [5:0] dt;
  logic       wc_legal;
  logic       unused_bits;

  always_comb begin
    dt         = hdr[DT_MSB:DI_LSB];
    wc         = hdr[WC_MSB:WC_LSB];
    wc_legal   = (wc != 16'd0) && (int'(wc) <= MAX_WC);
    ecc_err    = !hdr_ok;
    is_fs      = hdr_ok && (dt == DT_FS);
    is_fe      = hdr_ok && (dt == DT_FE);
    is_raw8_ok = hdr_ok && (dt == DT_RAW8) && wc_legal;
    len_err    = hdr_ok && (dt == DT_RAW8) && !wc_legal;
  end

  // Virtual channel and ECC byte are consumed upstream.
  assign unused_bits = ^{hdr[ECC_MSB:ECC_LSB], hdr[DI_MSB:VC_LSB]};

endmodule

// File: rtl/csi2_raw8_depacketizer.sv
// RAW8 CSI-2 depacketizer: decodes headers, tracks FS/FE and emits payload as
// 4-pixel words tagged with byte enables, column and line; the CRC is dropped.
module csi2_raw8_depacketizer #(
  parameter logic [5:0] DT_RAW8 = csi2_pkg::DT_RAW8,
  parameter int         MAX_WC  = 4096,
  parameter int         LINE_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stop,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_hdr_ok,
  input  logic [31:0]       in_data,
  output logic              px_valid,
  output logic [31:0]       px_data,
  output logic [3:0]        px_be,
  output logic [LINE_W-1:0] px_col,
  output logic [LINE_W-1:0] px_line,
  output logic              frame_start,
  output logic              frame_end,
  output logic              line_end,
  output logic              err_ecc,
  output logic              err_len,
  output logic              err_trunc,
  output logic              busy
);
  import csi2_pkg::*;

  state_t            state, state_nx;
  logic [15:0]       rem, rem_nx;
  logic [LINE_W-1:0] col, col_nx, line, line_nx;

  logic              is_fs, is_fe, is_raw8_ok, len_err, ecc_err;
  logic [15:0]       hdr_wc;
  logic              hdr_word, pay_word;

  logic              px_valid_nx, frame_start_nx, frame_end_nx, line_end_nx;
  logic              err_ecc_nx, err_len_nx, err_trunc_nx;
  logic [31:0]       px_data_nx;
  logic [3:0]        px_be_nx;
  logic [LINE_W-1:0] px_col_nx, px_line_nx;

  csi2_hdr_decode #(
    .DT_RAW8 (DT_RAW8),
    .MAX_WC  (MAX_WC)
  ) u_hdr_decode (
    .hdr        (in_data),
    .hdr_ok     (in_hdr_ok),
    .is_fs      (is_fs),
    .is_fe      (is_fe),
    .is_raw8_ok (is_raw8_ok),
    .len_err    (len_err),
    .ecc_err    (ecc_err),
    .wc         (hdr_wc)
  );

  // A header is honoured in IDLE and also mid-payload (that truncates the line).
  assign hdr_word = in_valid && in_first && (state != ST_DROP);
  assign pay_word = in_valid && !in_first && (state == ST_PAYLOAD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (stop) begin
      state_nx = ST_IDLE;
    end else if (hdr_word) begin
      state_nx = is_raw8_ok ? ST_PAYLOAD : ST_DROP;
    end else if (pay_word && (rem <= 16'd4)) begin
      state_nx = ST_DROP;
    end
  end

  always_comb begin
    px_valid_nx    = 1'b0;
    px_data_nx     = px_data;
    px_be_nx       = 4'h0;
    px_col_nx      = px_col;
    px_line_nx     = px_line;
    frame_start_nx = 1'b0;
    frame_end_nx   = 1'b0;
    line_end_nx    = 1'b0;
    err_ecc_nx     = 1'b0;
    err_len_nx     = 1'b0;
    err_trunc_nx   = 1'b0;
    rem_nx         = rem;
    col_nx         = col;
    line_nx        = line;
    if (stop) begin
      err_trunc_nx = (state == ST_PAYLOAD) && (rem != 16'd0);
    end else if (hdr_word) begin
      err_trunc_nx = (state == ST_PAYLOAD);
      if (ecc_err) begin
        err_ecc_nx = 1'b1;
      end else if (is_fs) begin
        frame_start_nx = 1'b1;
        line_nx        = '0;
      end else if (is_fe) begin
        frame_end_nx = 1'b1;
      end else if (is_raw8_ok) begin
        rem_nx = hdr_wc;
        col_nx = '0;
      end else if (len_err) begin
        err_len_nx = 1'b1;
      end
    end else if (pay_word) begin
      px_valid_nx = 1'b1;
      px_data_nx  = in_data;
      px_be_nx    = be_for_rem(rem);
      px_col_nx   = col;
      px_line_nx  = line;
      col_nx      = col + LINE_W'(4);
      rem_nx      = (rem >= 16'd4) ? (rem - 16'd4) : 16'd0;
      if (rem <= 16'd4) begin
        line_end_nx = 1'b1;
        line_nx     = line + LINE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem         <= '0;
      col         <= '0;
      line        <= '0;
      px_valid    <= 1'b0;
      px_data     <= '0;
      px_be       <= '0;
      px_col      <= '0;
      px_line     <= '0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      line_end    <= 1'b0;
      err_ecc     <= 1'b0;
      err_len     <= 1'b0;
      err_trunc   <= 1'b0;
    end else begin
      rem         <= rem_nx;
      col         <= col_nx;
      line        <= line_nx;
      px_valid    <= px_valid_nx;
      px_data     <= px_data_nx;
      px_be       <= px_be_nx;
      px_col      <= px_col_nx;
      px_line     <= px_line_nx;
      frame_start <= frame_start_nx;
      frame_end   <= frame_end_nx;
      line_end    <= line_end_nx;
      err_ecc     <= err_ecc_nx;
      err_len     <= err_len_nx;
      err_trunc   <= err_trunc_nx;
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_csi2_raw8_depacketizer.sv
// Directed bench for csi2_raw8_depacketizer: a packet-level model predicts every
// output cycle, and a few literal expectations pin the model to known answers.
module tb_csi2_raw8_depacketizer;

  typedef struct {
    logic        px_valid;
    logic [31:0] px_data;
    logic [3:0]  px_be;
    logic [15:0] px_col;
    logic [15:0] px_line;
    logic        fs, fe, le, eecc, elen, etrunc, busy;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1, stop = 1'b0, in_valid = 1'b0, in_first = 1'b0, in_hdr_ok = 1'b0;
  logic [31:0] in_data = '0;
  logic        px_valid, frame_start, frame_end, line_end, err_ecc, err_len, err_trunc, busy;
  logic [31:0] px_data;
  logic [3:0]  px_be;
  logic [15:0] px_col, px_line;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];

  // Packet-level model: line count, open payload (byte count, beats sent), last px tags.
  int          m_line = 0;
  bit          m_busy = 0;
  bit          m_active = 0;
  int          m_wc = 0;
  int          m_idx = 0;
  logic [31:0] last_data = '0;
  logic [15:0] last_col = '0;
  logic [15:0] last_line = '0;

  csi2_raw8_depacketizer dut (
    .clk         (clk),
    .reset       (reset),
    .stop        (stop),
    .in_valid    (in_valid),
    .in_first    (in_first),
    .in_hdr_ok   (in_hdr_ok),
    .in_data     (in_data),
    .px_valid    (px_valid),
    .px_data     (px_data),
    .px_be       (px_be),
    .px_col      (px_col),
    .px_line     (px_line),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .line_end    (line_end),
    .err_ecc     (err_ecc),
    .err_len     (err_len),
    .err_trunc   (err_trunc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t baseExp();
    exp_t e;
    e.px_valid = 1'b0;
    e.px_data  = last_data;
    e.px_be    = 4'h0;
    e.px_col   = last_col;
    e.px_line  = last_line;
    e.fs = 1'b0; e.fe = 1'b0; e.le = 1'b0;
    e.eecc = 1'b0; e.elen = 1'b0; e.etrunc = 1'b0;
    e.busy = m_busy;
    return e;
  endfunction

  task automatic applyStimulus(input logic rst, input logic stp, input logic v, input logic f,
                               input logic ok, input logic [31:0] d, input exp_t e);
    @(negedge clk);
    reset = rst; stop = stp; in_valid = v; in_first = f; in_hdr_ok = ok; in_data = d;
    exp_q.push_back(e);
  endtask

  task automatic doReset();
    exp_t e;
    m_line = 0; m_busy = 0; m_active = 0;
    last_data = '0; last_col = '0; last_line = '0;
    e = baseExp();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, e);
  endtask

  task automatic doIdle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, baseExp());
  endtask

  task automatic doHeader(input logic [5:0] dt, input int wc, input logic ok);
    exp_t        e;
    logic [15:0] w16;
    logic [31:0] w;
    w16 = 16'(wc);
    w   = {8'h5A, w16, 2'b01, dt};
    e   = baseExp();
    if (!(m_busy && !m_active)) begin
      if (m_active) e.etrunc = 1'b1;
      m_active = 0;
      if (!ok) e.eecc = 1'b1;
      else if (dt == 6'h00) begin e.fs = 1'b1; m_line = 0; end
      else if (dt == 6'h01) e.fe = 1'b1;
      else if (dt == 6'h2A) begin
        if (wc >= 1 && wc <= 4096) begin m_active = 1; m_wc = wc; m_idx = 0; end
        else e.elen = 1'b1;
      end
      m_busy = 1;
    end
    e.busy = m_busy;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, ok, w, e);
  endtask

  task automatic doWord(input logic [31:0] d);
    exp_t e;
    int   left;
    e = baseExp();
    if (m_active) begin
      left       = m_wc - 4 * m_idx;
      e.px_valid = 1'b1;
      e.px_data  = d;
      e.px_be    = (left >= 4) ? 4'hF : 4'((1 << left) - 1);
      e.px_col   = 16'(4 * m_idx);
      e.px_line  = 16'(m_line);
      last_data = e.px_data; last_col = e.px_col; last_line = e.px_line;
      m_idx++;
      if (4 * m_idx >= m_wc) begin
        e.le     = 1'b1;
        m_line   = (m_line + 1) % 65536;
        m_active = 0;
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, d, e);
  endtask

  task automatic doStop(input logic with_word);
    exp_t e;
    e = baseExp();
    if (m_active) e.etrunc = 1'b1;
    m_active = 0;
    m_busy   = 0;
    e.busy   = 1'b0;
    applyStimulus(1'b0, 1'b1, with_word, 1'b0, 1'b1, 32'hCAFEF00D, e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin : compare
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("px_valid",    32'(px_valid),    32'(e.px_valid));
        checkOutput("px_data",     px_data,          e.px_data);
        checkOutput("px_be",       32'(px_be),       32'(e.px_be));
        checkOutput("px_col",      32'(px_col),      32'(e.px_col));
        checkOutput("px_line",     32'(px_line),     32'(e.px_line));
        checkOutput("frame_start", 32'(frame_start), 32'(e.fs));
        checkOutput("frame_end",   32'(frame_end),   32'(e.fe));
        checkOutput("line_end",    32'(line_end),    32'(e.le));
        checkOutput("err_ecc",     32'(err_ecc),     32'(e.eecc));
        checkOutput("err_len",     32'(err_len),     32'(e.elen));
        checkOutput("err_trunc",   32'(err_trunc),   32'(e.etrunc));
        checkOutput("busy",        32'(busy),        32'(e.busy));
      end
    end
  end

  initial begin : stimulus
    doReset(); doReset();
    settle();
    checkOutput("lit_reset_busy", 32'(busy), 32'h0);
    checkOutput("lit_reset_be", 32'(px_be), 32'h0);
    doIdle();
    doWord(32'h11111111);

    // Frame start
    doHeader(6'h00, 16'h0055, 1'b1);
    settle();
    checkOutput("lit_fs_pulse", 32'(frame_start), 32'h1);
    checkOutput("lit_fs_line", 32'(px_line), 32'h0);
    doStop(1'b0);

    // Full 8-byte line with CRC footer dropped
    doHeader(6'h2A, 8, 1'b1);
    doWord(32'h04030201);
    doWord(32'h08070605);
    settle();
    checkOutput("lit_wc8_col", 32'(px_col), 32'h4);
    checkOutput("lit_wc8_le", 32'(line_end), 32'h1);
    doWord(32'hDEADBEEF);
    doStop(1'b0);

    // Partial last word
    doHeader(6'h2A, 6, 1'b1);
    doWord(32'h0C0B0A09);
    doWord(32'h00000E0D);
    settle();
    checkOutput("lit_wc6_be", 32'(px_be), 32'h3);
    checkOutput("lit_wc6_line", 32'(px_line), 32'h1);
    doWord(32'h12345678);
    doStop(1'b0);

    // Illegal word counts
    doHeader(6'h2A, 4097, 1'b1);
    settle();
    checkOutput("lit_wc4097_len", 32'(err_len), 32'h1);
    doWord(32'hAAAA5555);
    doStop(1'b0);
    doHeader(6'h2A, 0, 1'b1);
    doStop(1'b0);

    // Truncated line, then frame end
    doHeader(6'h2A, 12, 1'b1);
    doWord(32'h13121110);
    doWord(32'h17161514);
    doStop(1'b0);
    settle();
    checkOutput("lit_trunc_pulse", 32'(err_trunc), 32'h1);
    checkOutput("lit_trunc_busy", 32'(busy), 32'h0);
    doHeader(6'h01, 0, 1'b1);
    settle();
    checkOutput("lit_fe_pulse", 32'(frame_end), 32'h1);
    doStop(1'b0);

    // ECC failure: everything until stop is dropped, including a later FS header
    doHeader(6'h2A, 8, 1'b0);
    settle();
    checkOutput("lit_ecc_pulse", 32'(err_ecc), 32'h1);
    doWord(32'h01020304);
    doHeader(6'h00, 0, 1'b1);
    doStop(1'b0);

    // Unknown data type is silently skipped
    doHeader(6'h2B, 8, 1'b1);
    doWord(32'h55667788);
    doWord(32'h99AABBCC);
    doStop(1'b0);

    // Header arriving mid-payload truncates and is decoded
    doHeader(6'h2A, 8, 1'b1);
    doWord(32'h21212121);
    doHeader(6'h00, 0, 1'b1);
    settle();
    checkOutput("lit_hdr_in_pay_trunc", 32'(err_trunc), 32'h1);
    checkOutput("lit_hdr_in_pay_fs", 32'(frame_start), 32'h1);
    doStop(1'b0);

    // Stop with a word in the same cycle mid-payload
    doHeader(6'h2A, 8, 1'b1);
    doWord(32'h31313131);
    doStop(1'b1);

    // One- and three-byte lines
    doHeader(6'h2A, 1, 1'b1);
    doWord(32'h000000AB);
    settle();
    checkOutput("lit_wc1_be", 32'(px_be), 32'h1);
    doStop(1'b0);
    doHeader(6'h2A, 3, 1'b1);
    doWord(32'h00CDEF01);
    doStop(1'b0);

    // Reset in the middle of a payload
    doHeader(6'h2A, 16, 1'b1);
    doWord(32'h41414141);
    doReset();
    settle();
    checkOutput("lit_rst_data", px_data, 32'h0);
    checkOutput("lit_rst_busy", 32'(busy), 32'h0);
    doHeader(6'h2A, 4, 1'b1);
    doWord(32'h51515151);
    settle();
    checkOutput("lit_after_rst_line", 32'(px_line), 32'h0);
    checkOutput("lit_after_rst_le", 32'(line_end), 32'h1);
    doStop(1'b0);

    // Largest legal line
    doHeader(6'h2A, 4096, 1'b1);
    for (int i = 0; i < 1024; i++) doWord(32'(i) * 32'h00010003);
    settle();
    checkOutput("lit_wcmax_col", 32'(px_col), 32'd4092);
    checkOutput("lit_wcmax_line", 32'(px_line), 32'h1);
    doStop(1'b0);
    doIdle();
    doIdle();

    repeat (3) @(posedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/csi2_raw8_depacketizer.md
# csi2_raw8_depacketizer

Receives the ECC-checked 32-bit word stream of one MIPI CSI-2 HS burst, the output of the two-lane byte aligner plus the header checker, in the mipi byte-clock domain. Decodes the packet header and tracks frame start and frame end short packets. For RAW8 long packets, emits payload as 4-pixel words with byte enables, column address and line number, dropping the CRC footer. Sits directly downstream of the header/ECC stage and feeds the frame-buffer writer.

## Interface
Parameters:
- DT_RAW8, 6'h2A, data type accepted as pixel payload
- MAX_WC, 4096, largest legal long-packet word count (bytes)
- LINE_W, 16, width of column and line counters

Ports:
- clk  in  1  mipi byte clock
- reset  in  1  synchronous, active-high
- stop  in  1  HS burst ended (lanes back in LP); aborts the current packet
- in_valid  in  1  in_data holds a new word
- in_first  in  1  qualifies in_valid: word is the packet header (first word of the burst)
- in_hdr_ok  in  1  header ECC syndrome zero; sampled only with in_valid & in_first
- in_data  in  32  [7:0]=DI (VC[7:6], DT[5:0]), [23:8]=WC little-endian, [31:24]=ECC; payload bytes are little-endian, byte0 = leftmost pixel
- px_valid  out  1  px_* valid this cycle
- px_data  out  32  four RAW8 pixels
- px_be  out  4  byte enables; bit n qualifies px_data[8n+7:8n]
- px_col  out  LINE_W  column of byte0
- px_line  out  LINE_W  current line number within frame
- frame_start  out  1  one-cycle pulse on FS (DT 0x00)
- frame_end  out  1  one-cycle pulse on FE (DT 0x01)
- line_end  out  1  one-cycle pulse, coincident with the last px_valid of a line
- err_ecc  out  1  one-cycle pulse, header with in_hdr_ok=0
- err_len  out  1  one-cycle pulse, RAW8 WC == 0 or WC > MAX_WC
- err_trunc  out  1  one-cycle pulse, packet ended before WC bytes were delivered
- busy  out  1  state != IDLE

## Operation
- States: IDLE, PAYLOAD, DROP.
- IDLE, on in_valid & in_first:
  - !in_hdr_ok: pulse err_ecc, go to DROP.
  - DT 0x00: pulse frame_start, line <= 0, go to DROP.
  - DT 0x01: pulse frame_end, go to DROP.
  - DT == DT_RAW8 and 1 <= WC <= MAX_WC: rem <= WC, col <= 0, go to PAYLOAD.
  - DT == DT_RAW8 with an illegal WC: pulse err_len, go to DROP.
  - Any other DT: silently go to DROP.
  - in_valid without in_first is ignored.
- PAYLOAD, each in_valid word:
  - Output the word with px_be = 4'hF if rem >= 4, else the low rem bits set (rem 1 -> 4'h1, 2 -> 4'h3, 3 -> 4'h7).
  - px_col = col; then col += 4 and rem -= min(rem, 4).
  - If rem <= 4: pulse line_end, line += 1 (wraps modulo 2^LINE_W), go to DROP.
  - The CRC footer and any padding are discarded in DROP.
- PAYLOAD, in_valid & in_first: pulse err_trunc, line not incremented, and evaluate the word as a header exactly as in IDLE.
- DROP: ignore all words until stop.
- stop in any state: state <= IDLE next cycle. Any in_valid word in the same cycle is discarded. In PAYLOAD with rem > 0 this also pulses err_trunc and leaves line unchanged.
- The line counter is cleared only by reset or FS. A RAW8 line without a preceding FS still uses the current line value.

## Timing
- All outputs are registered, with a fixed latency of 1 cycle from the in_valid edge to px_valid, frame_start, frame_end, line_end and err_*.
- Back-to-back in_valid words are accepted every cycle. There is no backpressure; the downstream stage must absorb 1 word/cycle.
- Reset values: state IDLE, rem/col/line 0, and every output 0 (px_data 0, px_be 0, busy 0).
- reset has priority over stop, and stop has priority over in_valid.
- Simultaneous error conditions produce only the first applicable pulse in IDLE decode order.
- Outputs for the ignored word are 0. px_data, px_col and px_line hold their last value when px_valid = 0.

## Structure
- Shared package csi2_pkg holds:
  - data-type constants (DT_FS 6'h00, DT_FE 6'h01, DT_RAW8 6'h2A)
  - the state enum
  - header field bit positions (DI, WC, ECC)
- One natural sub-module, csi2_hdr_decode: combinational. It maps a header word plus in_hdr_ok to {is_fs, is_fe, is_raw8_ok, len_err, ecc_err, wc}. It is shared with the future YUV/RAW10 depacketizers.

## Test plan
- FS header 0x00xx0000 with hdr_ok=1, then stop -> frame_start pulse 1 cycle later, px_line reset to 0.
- RAW8 header WC=8, words 0x04030201, 0x08070605, CRC word, stop -> two px_valid with px_col 0 and 4, px_be F, F; line_end on the second; px_line increments 0 -> 1.
- RAW8 WC=6 -> second word px_be 4'h3 with line_end; WC=4097 -> err_len, no px_valid.
- RAW8 WC=12, stop after 2 payload words -> err_trunc, line unchanged, busy drops next cycle; the following FE -> frame_end.
- Header with hdr_ok=0 -> err_ecc, no pixels until after stop. DT 0x2B -> no outputs at all.
- reset asserted mid-PAYLOAD -> all outputs 0 the next cycle; the next header is decoded normally.
